// File: rtl/max7219_spi_chain_checker_pkg.sv
// Shared constants and sizing helpers for the MAX7219 display testbench checkers.
// Combinational only, so no latency or backpressure applies.
package max7219_tb_pkg;

   localparam int C_MAX7219_FRAME_WIDTH = 16;
   localparam int C_BIT_COUNT_WIDTH     = 16;

   // Captured entry layout, MSB first: {len_err, bit_count, shift_data}
   function automatic int f_entry_width(input int n_bits);
      return n_bits + C_BIT_COUNT_WIDTH + 1;
   endfunction

endpackage

// File: rtl/max7219_spi_chain_checker_fifo.sv
// Generic first-word-fall-through FIFO: a push becomes visible the next cycle and a pop exposes the next head the next cycle.
// A push while full is dropped and flagged as sticky overflow unless a pop frees a slot in the same cycle.
module tb_sync_fifo #(
   parameter int G_WIDTH = 8,
   parameter int G_DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_clear,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [G_WIDTH-1:0]         i_data,
   output logic [G_WIDTH-1:0]         o_data,
   output logic                       o_empty,
   output logic                       o_full,
   output logic [$clog2(G_DEPTH):0]   o_level,
   output logic                       o_overflow
);

   localparam int C_AW = $clog2(G_DEPTH);

   logic [G_WIDTH-1:0] r_mem [G_DEPTH];
   logic [C_AW-1:0]    r_wr_ptr;
   logic [C_AW-1:0]    r_rd_ptr;
   logic [C_AW:0]      r_level;
   logic               r_overflow;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;

   assign w_empty = (r_level == '0);
   assign w_full  = (r_level == (C_AW+1)'(G_DEPTH));
   assign w_pop   = i_pop & ~w_empty;
   assign w_push  = i_push & (~w_full | w_pop);

   always_ff @(posedge clk) begin
      if (w_push && !i_clear) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else if (i_clear) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + 1'b1;
         end else if (w_pop && !w_push) begin
            r_level <= r_level - 1'b1;
         end
         if (i_push && !w_push) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Head is forced to zero when empty so the outputs are defined out of reset.
   assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_empty    = w_empty;
   assign o_full     = w_full;
   assign o_level    = r_level;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/max7219_spi_chain_checker.sv
// Captures MAX7219 chain traffic into FWFT frame entries; events appear G_SYNC_STAGES+2 cycles after the pin edge.
// Passive observer: it never stalls the bus, and loads arriving while the FIFO is full are dropped and flagged.
module max7219_spi_chain_checker
   import max7219_tb_pkg::*;
#(
   parameter int G_NB_CHAIN    = 8,
   parameter int G_FRAME_WIDTH = C_MAX7219_FRAME_WIDTH,
   parameter int G_FIFO_DEPTH  = 16,
   parameter int G_SYNC_STAGES = 2,
   parameter int G_SAMPLE_EDGE = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_max7219_clk,
   input  logic                                 i_max7219_din,
   input  logic                                 i_max7219_load,
   input  logic                                 i_clear,
   input  logic                                 i_pop,
   output logic                                 o_frame_received,
   output logic                                 o_load_received,
   output logic                                 o_len_error,
   output logic [G_NB_CHAIN*G_FRAME_WIDTH-1:0]  o_data,
   output logic [C_BIT_COUNT_WIDTH-1:0]         o_bit_count,
   output logic                                 o_head_err,
   output logic                                 o_empty,
   output logic                                 o_full,
   output logic [$clog2(G_FIFO_DEPTH):0]        o_level,
   output logic                                 o_overflow
);

   localparam int C_N  = G_NB_CHAIN * G_FRAME_WIDTH;
   localparam int C_EW = f_entry_width(C_N);
   localparam int C_WW = $clog2(G_FRAME_WIDTH);

   logic [2:0]                   w_pins;
   logic [2:0]                   w_sync;
   logic [2:0]                   r_d1;
   logic [2:0]                   r_d2;
   logic                         w_clk_rise;
   logic                         w_clk_fall;
   logic                         w_sample;
   logic                         w_load_rise;
   logic                         w_inc;
   logic                         w_word_end;
   logic                         w_len_err;
   logic [C_N-1:0]               w_shift_next;
   logic [C_BIT_COUNT_WIDTH-1:0] w_count_next;
   logic [C_EW-1:0]              w_entry;
   logic [C_EW-1:0]              w_head;

   logic [C_N-1:0]               r_shift;
   logic [C_BIT_COUNT_WIDTH-1:0] r_bit_count;
   logic [C_WW-1:0]              r_word_bits;
   logic                         r_frame_pulse;
   logic                         r_load_pulse;
   logic                         r_len_pulse;

   assign w_pins = {i_max7219_load, i_max7219_clk, i_max7219_din};

   generate
      if (G_SYNC_STAGES == 0) begin : g_nosync
         assign w_sync = w_pins;
      end else begin : g_sync
         logic [2:0] r_sync [G_SYNC_STAGES];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < G_SYNC_STAGES; i++) begin
                  r_sync[i] <= '0;
               end
            end else begin
               r_sync[0] <= w_pins;
               for (int i = 1; i < G_SYNC_STAGES; i++) begin
                  r_sync[i] <= r_sync[i-1];
               end
            end
         end
         assign w_sync = r_sync[G_SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d1 <= '0;
         r_d2 <= '0;
      end else begin
         r_d1 <= w_sync;
         r_d2 <= r_d1;
      end
   end

   assign w_clk_rise  = r_d1[1] & ~r_d2[1];
   assign w_clk_fall  = ~r_d1[1] & r_d2[1];
   assign w_sample    = (G_SAMPLE_EDGE != 0) ? w_clk_rise : w_clk_fall;
   assign w_load_rise = r_d1[2] & ~r_d2[2];

   // A bit sampled in the load cycle is folded into the captured entry.
   assign w_inc        = w_sample && (r_bit_count != '1);
   assign w_shift_next = w_sample ? {r_shift[C_N-2:0], r_d1[0]} : r_shift;
   assign w_count_next = w_inc ? r_bit_count + 1'b1 : r_bit_count;
   assign w_word_end   = w_inc && (r_word_bits == C_WW'(G_FRAME_WIDTH - 1));
   assign w_len_err    = (w_count_next != C_BIT_COUNT_WIDTH'(C_N));
   assign w_entry      = {w_len_err, w_count_next, w_shift_next};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift       <= '0;
         r_bit_count   <= '0;
         r_word_bits   <= '0;
         r_frame_pulse <= 1'b0;
         r_load_pulse  <= 1'b0;
         r_len_pulse   <= 1'b0;
      end else begin
         r_frame_pulse <= w_word_end;
         r_load_pulse  <= w_load_rise;
         r_len_pulse   <= w_load_rise & w_len_err;
         if (i_clear || w_load_rise) begin
            r_shift     <= '0;
            r_bit_count <= '0;
            r_word_bits <= '0;
         end else begin
            r_shift     <= w_shift_next;
            r_bit_count <= w_count_next;
            if (w_inc) begin
               r_word_bits <= w_word_end ? '0 : r_word_bits + 1'b1;
            end
         end
      end
   end

   tb_sync_fifo #(
      .G_WIDTH (C_EW),
      .G_DEPTH (G_FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (i_clear),
      .i_push     (w_load_rise),
      .i_pop      (i_pop),
      .i_data     (w_entry),
      .o_data     (w_head),
      .o_empty    (o_empty),
      .o_full     (o_full),
      .o_level    (o_level),
      .o_overflow (o_overflow)
   );

   assign o_frame_received = r_frame_pulse;
   assign o_load_received  = r_load_pulse;
   assign o_len_error      = r_len_pulse;
   assign o_head_err       = w_head[C_EW-1];
   assign o_bit_count      = w_head[C_N +: C_BIT_COUNT_WIDTH];
   assign o_data           = w_head[C_N-1:0];

endmodule

// File: tb/tb_max7219_spi_chain_checker.sv
// Directed bench for the MAX7219 chain checker: default, depth-2 and falling-edge instances share one SPI bus.
module tb_max7219_spi_chain_checker;

   logic clk;
   logic rst_n;
   logic sclk, din, load, clr, pop;

   logic         a_frame, a_load, a_lenerr, a_head_err, a_empty, a_full, a_overflow;
   logic [127:0] a_data;
   logic [15:0]  a_bit_count;
   logic [4:0]   a_level;

   logic         b_frame, b_load, b_lenerr, b_head_err, b_empty, b_full, b_overflow;
   logic [127:0] b_data;
   logic [15:0]  b_bit_count;
   logic [1:0]   b_level;

   logic         c_frame, c_load, c_lenerr, c_head_err, c_empty, c_full, c_overflow;
   logic [127:0] c_data;
   logic [15:0]  c_bit_count;
   logic [4:0]   c_level;

   int n_vec = 0;
   int n_err = 0;
   int n_frames, n_loads, n_lenerr;
   logic cnt_clr;
   logic [127:0] v;

   max7219_spi_chain_checker u_dut (
      .clk(clk), .rst_n(rst_n), .i_max7219_clk(sclk), .i_max7219_din(din),
      .i_max7219_load(load), .i_clear(clr), .i_pop(pop),
      .o_frame_received(a_frame), .o_load_received(a_load), .o_len_error(a_lenerr),
      .o_data(a_data), .o_bit_count(a_bit_count), .o_head_err(a_head_err),
      .o_empty(a_empty), .o_full(a_full), .o_level(a_level), .o_overflow(a_overflow)
   );

   max7219_spi_chain_checker #(.G_FIFO_DEPTH(2)) u_dut_d2 (
      .clk(clk), .rst_n(rst_n), .i_max7219_clk(sclk), .i_max7219_din(din),
      .i_max7219_load(load), .i_clear(clr), .i_pop(pop),
      .o_frame_received(b_frame), .o_load_received(b_load), .o_len_error(b_lenerr),
      .o_data(b_data), .o_bit_count(b_bit_count), .o_head_err(b_head_err),
      .o_empty(b_empty), .o_full(b_full), .o_level(b_level), .o_overflow(b_overflow)
   );

   max7219_spi_chain_checker #(.G_SAMPLE_EDGE(0)) u_dut_fe (
      .clk(clk), .rst_n(rst_n), .i_max7219_clk(sclk), .i_max7219_din(din),
      .i_max7219_load(load), .i_clear(clr), .i_pop(pop),
      .o_frame_received(c_frame), .o_load_received(c_load), .o_len_error(c_lenerr),
      .o_data(c_data), .o_bit_count(c_bit_count), .o_head_err(c_head_err),
      .o_empty(c_empty), .o_full(c_full), .o_level(c_level), .o_overflow(c_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event pulses of the default instance, sampled mid-cycle.
   always @(negedge clk) begin
      if (cnt_clr) begin
         n_frames <= 0;
         n_loads  <= 0;
         n_lenerr <= 0;
      end else begin
         if (a_frame)  n_frames <= n_frames + 1;
         if (a_load)   n_loads  <= n_loads + 1;
         if (a_lenerr) n_lenerr <= n_lenerr + 1;
      end
   end

   task automatic check_val(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bit(input logic b);
      din = b;
      tick(5);
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
   endtask

   task automatic spi_bit_fe(input logic b);
      sclk = 1'b1;
      din  = b;
      tick(5);
      sclk = 1'b0;
      tick(5);
   endtask

   task automatic send_bits(input logic [31:0] val, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) spi_bit(val[i]);
   endtask

   task automatic spi_load();
      tick(5);
      load = 1'b1;
      tick(5);
      load = 1'b0;
      tick(6);
   endtask

   task automatic do_clear();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(1);
   endtask

   task automatic clear_counts();
      cnt_clr = 1'b1;
      tick(1);
      cnt_clr = 1'b0;
      tick(1);
   endtask

   task automatic pop_once();
      pop = 1'b1;
      tick(1);
      pop = 1'b0;
   endtask

   initial begin
      sclk = 0; din = 0; load = 0; clr = 0; pop = 0; cnt_clr = 0; rst_n = 0;
      tick(3);
      check_val("reset_state",
         {a_frame, a_load, a_lenerr, a_data, a_bit_count, a_head_err, a_full, a_level, a_overflow, a_empty},
         160'h1);
      rst_n = 1'b1;
      tick(2);

      // 1: full chain of 0x0C01 words
      clear_counts();
      for (int w = 0; w < 8; w++) send_bits(32'h0C01, 16);
      spi_load();
      check_val("t1_frames", n_frames, 8);
      check_val("t1_loads", n_loads, 1);
      check_val("t1_lenerr", n_lenerr, 0);
      check_val("t1_data", a_data, {8{16'h0C01}});
      check_val("t1_bitcount", a_bit_count, 128);
      check_val("t1_head_err", a_head_err, 0);
      check_val("t1_level", a_level, 1);
      pop_once();
      check_val("t1_empty_after_pop", a_empty, 1);

      // 2: 100 alternating bits, short frame
      do_clear();
      clear_counts();
      for (int k = 0; k < 100; k++) spi_bit(k % 2 == 0);
      spi_load();
      check_val("t2_lenerr", n_lenerr, 1);
      check_val("t2_frames", n_frames, 6);
      check_val("t2_bitcount", a_bit_count, 100);
      check_val("t2_upper_zero", a_data[127:100], 0);
      check_val("t2_data", a_data, 128'h0000000_AAAAA_AAAAA_AAAAA_AAAAA_AAAAA);
      check_val("t2_head_err", a_head_err, 1);

      // 3: depth-2 FIFO overflow, then push accepted alongside a pop while full
      do_clear();
      send_bits(32'hA, 4);
      spi_load();
      send_bits(32'h5, 4);
      spi_load();
      check_val("t3_full", b_full, 1);
      check_val("t3_level2", b_level, 2);
      check_val("t3_no_ovf_yet", b_overflow, 0);
      send_bits(32'hF, 4);
      spi_load();
      check_val("t3_overflow", b_overflow, 1);
      check_val("t3_level_kept", b_level, 2);
      check_val("t3_head_first", {b_head_err, b_bit_count, b_data}, {1'b1, 16'd4, 128'hA});
      send_bits(32'h3, 4);
      tick(5);
      load = 1'b1;
      tick(3);
      pop = 1'b1;
      tick(1);
      pop = 1'b0;
      check_val("t3_load_pulse_e1", b_load, 1);
      check_val("t3_level_pushpop", b_level, 2);
      check_val("t3_head_second", b_data, 128'h5);
      tick(2);
      load = 1'b0;
      tick(6);
      pop_once();
      check_val("t3_head_new", b_data, 128'h3);
      check_val("t3_level_after_pop", b_level, 1);
      do_clear();
      check_val("t3_clear_ovf", b_overflow, 0);
      check_val("t3_clear_level", b_level, 0);

      // 4: falling-edge sampling, din changes on the rising edge
      for (int i = 15; i >= 0; i--) begin
         v = 128'h0F00;
         spi_bit_fe(v[i]);
      end
      spi_load();
      check_val("t4_data", c_data, 128'h0F00);
      check_val("t4_bitcount", c_bit_count, 16);
      check_val("t4_level", c_level, 1);

      // 5: reset in the middle of a frame
      do_clear();
      send_bits(32'h3, 4);
      spi_load();
      send_bits(32'hDEADBEEF, 32);
      send_bits(32'h55, 8);
      rst_n = 1'b0;
      tick(2);
      check_val("t5_in_reset",
         {a_frame, a_load, a_lenerr, a_data, a_bit_count, a_head_err, a_full, a_level, a_overflow, a_empty},
         160'h1);
      rst_n = 1'b1;
      tick(2);
      for (int w = 0; w < 8; w++) send_bits(32'hA55A, 16);
      spi_load();
      check_val("t5_level", a_level, 1);
      check_val("t5_bitcount", a_bit_count, 128);
      check_val("t5_head_err", a_head_err, 0);
      check_val("t5_data", a_data, {8{16'hA55A}});

      // 6: last bit and load in the same edge cycle, then clear
      do_clear();
      clear_counts();
      v = {8{16'h0C01}};
      for (int i = 127; i >= 1; i--) spi_bit(v[i]);
      din = v[0];
      tick(5);
      sclk = 1'b1;
      load = 1'b1;
      tick(5);
      sclk = 1'b0;
      load = 1'b0;
      tick(6);
      check_val("t6_bitcount", a_bit_count, 128);
      check_val("t6_head_err", a_head_err, 0);
      check_val("t6_data", a_data, {8{16'h0C01}});
      check_val("t6_frames", n_frames, 8);
      check_val("t6_lenerr", n_lenerr, 0);
      do_clear();
      check_val("t6_clear_empty", a_empty, 1);
      check_val("t6_clear_level", a_level, 0);
      check_val("t6_clear_ovf", a_overflow, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
